// File: rtl/day4_pkg.sv
// day4_pkg: shared constants, FSM encoding and small byte-classification
// helpers for the Day 4 ASCII loader.
package day4_pkg;

    // ASCII bytes recognised by the parser
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_PARSE = 2'd0,
        ST_TERM  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Field index within a record: start0-end0,start1-end1
    localparam logic [1:0] FLD_START0 = 2'd0;
    localparam logic [1:0] FLD_END0   = 2'd1;
    localparam logic [1:0] FLD_START1 = 2'd2;
    localparam logic [1:0] FLD_END1   = 2'd3;

    // Default geometry
    localparam int DEF_ADDR_W  = 14;
    localparam int DEF_MAX_VAL = 99;

    // Separator byte that must terminate the given field
    function automatic logic [7:0] field_sep(input logic [1:0] fld);
        logic [7:0] sep;
        case (fld)
            FLD_START0: sep = CH_DASH;
            FLD_END0:   sep = CH_COMMA;
            FLD_START1: sep = CH_DASH;
            default:    sep = CH_LF;
        endcase
        return sep;
    endfunction

    // True for ASCII '0'..'9'
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/day4_loader_dec_acc.sv
// day4_dec_acc: decimal digit accumulator. Holds the value of the field being
// parsed, counts digits seen, and flags (combinationally) when the incoming
// digit would push the value above MAX_VAL.
module day4_dec_acc
    import day4_pkg::*;
#(
    parameter int MAX_VAL = DEF_MAX_VAL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       dig_en,
    input  logic [3:0] dig,
    output logic [7:0] value,
    output logic [3:0] ndig,
    output logic [7:0] next_val,
    output logic       ovf
);

    logic [10:0] prod;

    // Candidate value after shifting in the current digit, with range check
    always_comb begin
        prod     = ({3'b000, value} * 11'd10) + {7'b0000000, dig};
        next_val = prod[7:0];
        ovf      = (prod > 11'(MAX_VAL));
    end

    // Accumulator and saturating digit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 8'd0;
            ndig  <= 4'd0;
        end else if (clr) begin
            value <= 8'd0;
            ndig  <= 4'd0;
        end else if (dig_en) begin
            value <= next_val;
            if (ndig != 4'hF) begin
                ndig <= ndig + 4'd1;
            end
        end
    end

endmodule

// File: rtl/day4_loader.sv
// day4_loader: streaming parser for "a-b,c-d" lines. Each record is written
// as four bytes (start0, end0, start1, end1); a 0x00 terminator follows the
// last record. Writes are registered (one cycle after the separator).
// Optional feature: DAY4_RANGE_CHECK_EN rejects pairs whose end < start.
module day4_loader
    import day4_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MAX_VAL = DEF_MAX_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [15:0]       record_count,
    output logic              done,
    output logic              err
);

    state_t            state;
    state_t            state_n;
    logic [1:0]        field;
    logic [ADDR_W-1:0] addr;

    logic [7:0]        acc_val;
    logic [3:0]        acc_ndig;
    logic [7:0]        acc_next;
    logic              acc_ovf;
    logic              acc_clr;
    logic              acc_dig;

    logic              xfer;
    logic              addr_full;
    logic              range_bad_sep;
    logic              range_bad_dig;

    logic              wr_en_p0;
    logic [7:0]        wr_data_p0;
    logic              rec_wr;
    logic              rec_inc;

    day4_dec_acc #(
        .MAX_VAL (MAX_VAL)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .dig_en   (acc_dig),
        .dig      (in_data[3:0]),
        .value    (acc_val),
        .ndig     (acc_ndig),
        .next_val (acc_next),
        .ovf      (acc_ovf)
    );

    // Byte acceptance is a pure function of state; held low while in reset
    assign in_ready  = (state == ST_PARSE) && !rst;
    assign xfer      = in_valid && in_ready;
    // Top slot is reserved for the terminator
    assign addr_full = (addr == {ADDR_W{1'b1}});

`ifdef DAY4_RANGE_CHECK_EN
    logic [7:0] start_q;

    // Remember the start of the current pair for the end >= start check
    always_ff @(posedge clk) begin
        if (rec_wr && !field[0]) begin
            start_q <= acc_val;
        end
    end

    assign range_bad_sep = field[0] && (acc_val < start_q);
    assign range_bad_dig = (acc_next < start_q);
`else
    assign range_bad_sep = 1'b0;
    assign range_bad_dig = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_PARSE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and write decision for the byte presented this cycle
    always_comb begin
        state_n    = state;
        wr_en_p0   = 1'b0;
        wr_data_p0 = acc_val;
        rec_wr     = 1'b0;
        rec_inc    = 1'b0;
        acc_clr    = 1'b0;
        acc_dig    = 1'b0;
        case (state)
            ST_PARSE: begin
                if (xfer) begin
                    if (is_digit(in_data)) begin
                        if (acc_ovf) begin
                            state_n = ST_ERROR;
                        end else begin
                            acc_dig = 1'b1;
                            if (in_last) begin
                                // Unterminated last record: flush end1 directly
                                if ((field == FLD_END1) && (acc_next != 8'd0) &&
                                    !addr_full && !range_bad_dig) begin
                                    wr_en_p0   = 1'b1;
                                    wr_data_p0 = acc_next;
                                    rec_wr     = 1'b1;
                                    rec_inc    = 1'b1;
                                    state_n    = ST_TERM;
                                end else begin
                                    state_n = ST_ERROR;
                                end
                            end
                        end
                    end else if (in_data == CH_CR) begin
                        if (in_last) begin
                            state_n = ((field == FLD_START0) && (acc_ndig == 4'd0)) ?
                                      ST_TERM : ST_ERROR;
                        end
                    end else if ((in_data == field_sep(field)) && (acc_ndig != 4'd0) &&
                                 (acc_val != 8'd0) && !addr_full && !range_bad_sep) begin
                        if (in_last && (field != FLD_END1)) begin
                            state_n = ST_ERROR;
                        end else begin
                            wr_en_p0 = 1'b1;
                            rec_wr   = 1'b1;
                            acc_clr  = 1'b1;
                            rec_inc  = (field == FLD_END1);
                            if (in_last) begin
                                state_n = ST_TERM;
                            end
                        end
                    end else begin
                        state_n = ST_ERROR;
                    end
                end
            end
            ST_TERM: begin
                wr_en_p0   = 1'b1;
                wr_data_p0 = 8'h00;
                state_n    = ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_DONE;
            end
            ST_ERROR: begin
                state_n = ST_ERROR;
            end
            default: begin
                state_n = ST_ERROR;
            end
        endcase
    end

    // Registered write port, address/field tracking and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 8'd0;
            addr         <= '0;
            field        <= FLD_START0;
            record_count <= 16'd0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            wr_en <= wr_en_p0;
            if (wr_en_p0) begin
                wr_addr <= addr;
                wr_data <= wr_data_p0;
            end
            if (rec_wr) begin
                addr  <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                field <= field + 2'd1;
            end
            if (rec_inc) begin
                record_count <= record_count + 16'd1;
            end
            err  <= (state_n == ST_ERROR);
            done <= (state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_day4_loader.sv
// Scoreboard bench for day4_loader: a text-level reference model predicts the
// memory writes and final status of each byte stream; a monitor pops and
// compares every write the DUT issues.
module tb_day4_loader;

    localparam int AW   = 6;
    localparam int MAXV = 99;
    localparam int CAP  = (1 << AW) - 1;
`ifdef DAY4_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [15:0]   record_count;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    day4_loader #(.ADDR_W(AW), .MAX_VAL(MAXV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .record_count(record_count),
        .done(done), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_wr_cyc = -1;
    int done_cyc = -1;
    int err_cyc = -1;
    logic [7:0]  stim_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] pk(input int a, input int v);
        logic [15:0] r;
        r[15:8] = a[7:0];
        r[7:0]  = v[7:0];
        return r;
    endfunction

    // Monitor: every DUT write must match the head of the expected queue
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", int'(wr_addr), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), int'(mon_e[15:8]));
                    chk("wr_data", int'(wr_data), int'(mon_e[7:0]));
                end
                last_wr_cyc = cyc;
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
        end
    end

    // Reference model: parse the text stream, push expected writes.
    // oc: 1 = terminator written (done), 2 = error
    task automatic model(output int nsend, output int rc, output int oc);
        int val, nd, fld, a, st;
        logic [7:0] ch;
        bit last;
        logic [7:0] seps [4];
        seps = '{8'h2D, 8'h2C, 8'h2D, 8'h0A};
        val = 0; nd = 0; fld = 0; a = 0; st = 0; rc = 0; oc = 2;
        nsend = stim_q.size();
        for (int i = 0; i < stim_q.size(); i++) begin
            ch = stim_q[i];
            last = (i == stim_q.size() - 1);
            nsend = i + 1;
            if (ch >= 8'h30 && ch <= 8'h39) begin
                val = val * 10 + int'(ch - 8'h30);
                nd++;
                if (val > MAXV) begin oc = 2; break; end
                if (last) begin
                    if (fld == 3 && val >= 1 && a != CAP && !(RC && val < st)) begin
                        exp_q.push_back(pk(a, val));
                        rc++;
                        exp_q.push_back(pk(a + 1, 0));
                        oc = 1;
                    end else begin
                        oc = 2;
                    end
                    break;
                end
            end else if (ch == 8'h0D) begin
                if (last) begin
                    if (fld == 0 && nd == 0) begin
                        exp_q.push_back(pk(a, 0));
                        oc = 1;
                    end else begin
                        oc = 2;
                    end
                    break;
                end
            end else if (ch == seps[fld] && nd >= 1 && val >= 1 && a != CAP &&
                         !(RC && (fld % 2 == 1) && val < st)) begin
                if (last && fld != 3) begin oc = 2; break; end
                exp_q.push_back(pk(a, val));
                if (fld % 2 == 0) st = val;
                if (fld == 3) rc++;
                a++;
                fld = (fld + 1) % 4;
                val = 0;
                nd = 0;
                if (last) begin
                    exp_q.push_back(pk(a, 0));
                    oc = 1;
                    break;
                end
            end else begin
                oc = 2;
                break;
            end
        end
    endtask

    // Send the first ns bytes of stim_q with random idle gaps
    task automatic drive(input int ns, output int acc_e, input int maxgap);
        bit got;
        acc_e = -100;
        @(posedge clk); #1;
        for (int i = 0; i < ns; i++) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            if (gap > 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(0, 255));
                in_last  = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = stim_q[i];
            in_last  = (i == stim_q.size() - 1);
            got = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (in_ready === 1'b1) begin got = 1'b1; break; end
            end
            if (!got) begin
                chk("handshake_timeout", 0, 1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            acc_e = cyc + 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_str(input string s);
        stim_q.delete();
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    task automatic run_case(input string nm, input int maxgap, input bit pre_rst);
        int ns, rc, oc, acc_e;
        if (pre_rst) do_reset();
        last_wr_cyc = -1; done_cyc = -1; err_cyc = -1;
        model(ns, rc, oc);
        drive(ns, acc_e, maxgap);
        repeat (6) @(negedge clk);
        chk({nm, "_writes_missing"}, exp_q.size(), 0);
        chk({nm, "_record_count"}, int'(record_count), rc);
        chk({nm, "_done"}, int'(done), (oc == 1) ? 1 : 0);
        chk({nm, "_err"}, int'(err), (oc == 2) ? 1 : 0);
        chk({nm, "_in_ready"}, int'(in_ready), 0);
        if (oc == 1) begin
            chk({nm, "_term_latency"}, last_wr_cyc - acc_e, 1);
            chk({nm, "_done_latency"}, done_cyc - acc_e, 2);
        end else begin
            chk({nm, "_err_latency"}, err_cyc - acc_e, 0);
        end
        exp_q.delete();
    endtask

    task automatic gen_random();
        int nrec, v, st, mode, n;
        logic [7:0] seps [4];
        string s;
        seps = '{8'h2D, 8'h2C, 8'h2D, 8'h0A};
        stim_q.delete();
        st = 1;
        nrec = $urandom_range(1, 8);
        for (int r = 0; r < nrec; r++) begin
            for (int f = 0; f < 4; f++) begin
                case ($urandom_range(0, 39))
                    0:       v = 0;
                    1:       v = $urandom_range(100, 130);
                    default: v = (f % 2 == 1 && $urandom_range(0, 3) != 0) ?
                                 st + $urandom_range(0, 99 - st) : $urandom_range(1, 99);
                endcase
                if (f % 2 == 0) st = (v >= 1 && v <= 99) ? v : 1;
                if ($urandom_range(0, 7) == 0) stim_q.push_back(8'h30);
                s = $sformatf("%0d", v);
                for (int k = 0; k < s.len(); k++) stim_q.push_back(s[k]);
                if (f == 3 && $urandom_range(0, 3) == 0) stim_q.push_back(8'h0D);
                stim_q.push_back(seps[f]);
            end
        end
        mode = $urandom_range(0, 3);
        if (mode == 1) begin
            void'(stim_q.pop_back());
            if (stim_q[stim_q.size() - 1] == 8'h0D) void'(stim_q.pop_back());
        end else if (mode == 2) begin
            stim_q.push_back(8'h0D);
        end else if (mode == 3) begin
            n = $urandom_range(1, stim_q.size());
            while (stim_q.size() > n) void'(stim_q.pop_back());
        end
        if ($urandom_range(0, 9) == 0) stim_q[$urandom_range(0, stim_q.size() - 1)] = 8'h78;
    endtask

    initial begin
        int ns, rc, oc, acc_e;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_record_count", int'(record_count), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_rst", int'(in_ready), 1);

        load_str("2-4,6-8\n");                 run_case("one_rec", 0, 1'b1);
        load_str("2-4,6-8\n5-7,7-9");          run_case("no_final_lf", 2, 1'b1);
        load_str("12-99,1-100\n");             run_case("overflow", 1, 1'b1);
        load_str("0-3,4-5\n");                 run_case("zero_val", 0, 1'b1);
        load_str("5-3,1-2\n");                 run_case("inverted", 1, 1'b1);
        load_str("3-4,5-6\r\n7-8,9-9\n\r");    run_case("crlf_blank", 2, 1'b1);
        load_str("1-2,3-4\n5-");               run_case("last_on_dash", 0, 1'b1);
        stim_q.delete();
        for (int r = 0; r < 16; r++) begin
            string s;
            s = "1-2,3-4\n";
            for (int k = 0; k < s.len(); k++) stim_q.push_back(s[k]);
        end
        run_case("capacity", 0, 1'b1);

        for (int i = 0; i < 14; i++) begin
            gen_random();
            run_case($sformatf("rand%0d", i), 3, 1'b1);
        end

        // Reset in the middle of the second record, then replay from scratch
        do_reset();
        last_wr_cyc = -1; done_cyc = -1; err_cyc = -1;
        load_str("1-2,3-4\n5-6,7-8\n");
        model(ns, rc, oc);
        drive(10, acc_e, 2);
        @(negedge clk);
        #1 chk("mid_record_count", int'(record_count), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", int'(wr_en), 0);
        chk("mid_rst_wr_addr", int'(wr_addr), 0);
        chk("mid_rst_wr_data", int'(wr_data), 0);
        chk("mid_rst_record_count", int'(record_count), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        load_str("1-1,1-1\n");
        run_case("replay", 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
